// File: rtl/approx_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
package approx_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned DefN    = 16;
  localparam int unsigned DefCntW = 32;
  localparam int unsigned DefAccW = 48;

  // Error distance of an N-bit adder spans the full N+1-bit result range.
  function automatic int unsigned ed_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b|.
module abs_diff #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/approx_error_monitor.sv
// Collects error count, sum and max of error distance for an approximate adder over a run.
module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [N-1:0]     s_apx,
  input  logic             co_apx,
  output logic             busy,
  output logic             res_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N:0]       max_ed
);

  localparam int unsigned EdW = ed_width(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [EdW-1:0]   max_ed_q, max_ed_d;
  logic [EdW-1:0]   exact_q, exact_d;
  logic [EdW-1:0]   apx_q, apx_d;
  logic             s1_valid_q, s1_valid_d;

  logic [EdW-1:0]   ed;
  logic [ACC_W:0]   sum_ext;
  logic             xfer;
  logic             start_ok;

  abs_diff #(
    .W (EdW)
  ) u_abs_diff (
    .a_i    (exact_q),
    .b_i    (apx_q),
    .diff_o (ed)
  );

  assign in_ready  = (state_q == StRun) && (accepted_q < target_q);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && (state_q != StRun);
  // One spare bit catches the carry that signals saturation.
  assign sum_ext   = {1'b0, sum_ed_q} + {{(ACC_W - N){1'b0}}, ed};

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    accepted_d   = accepted_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    exact_d      = exact_q;
    apx_d        = apx_q;
    s1_valid_d   = xfer;

    if (xfer) begin
      exact_d    = {1'b0, x} + {1'b0, y};
      apx_d      = {co_apx, s_apx};
      accepted_d = accepted_q + CNT_W'(1);
    end

    if (s1_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_cnt_d    = err_cnt_q + {{(CNT_W - 1){1'b0}}, (ed != '0)};
      sum_ed_d     = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (ed > max_ed_q) max_ed_d = ed;
    end

    // The last sample leaves stage 1 on the same edge that enters DONE.
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (accepted_q == target_q) state_d = StDone;
      default:        state_d = StIdle;
    endcase

    if (start_ok) begin
      target_d     = num_samples;
      accepted_d   = '0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
      s1_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      target_q     <= '0;
      accepted_q   <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      exact_q      <= '0;
      apx_q        <= '0;
      s1_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      accepted_q   <= accepted_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
      exact_q      <= exact_d;
      apx_q        <= apx_d;
      s1_valid_q   <= s1_valid_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign res_valid  = (state_q == StDone);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomized self-checking bench; a second instance with an 18-bit accumulator checks saturation.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, co_apx;
  logic [31:0] num_samples;
  logic [15:0] x, y, s_apx;

  logic        in_ready, busy, res_valid;
  logic [31:0] sample_cnt, err_cnt;
  logic [47:0] sum_ed;
  logic [16:0] max_ed;

  logic        in_ready_s, busy_s, res_valid_s;
  logic [31:0] sample_cnt_s, err_cnt_s;
  logic [17:0] sum_ed_s;
  logic [16:0] max_ed_s;

  int total = 0;
  int bad   = 0;

  logic [15:0] qx[$], qy[$], qs[$];
  logic        qc[$];

  always #5 clk = ~clk;

  approx_error_monitor #(.N(16), .CNT_W(32), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .s_apx(s_apx), .co_apx(co_apx),
    .busy(busy), .res_valid(res_valid), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  approx_error_monitor #(.N(16), .CNT_W(32), .ACC_W(18)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .x(x), .y(y), .s_apx(s_apx), .co_apx(co_apx),
    .busy(busy_s), .res_valid(res_valid_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
    .sum_ed(sum_ed_s), .max_ed(max_ed_s)
  );

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                      input logic c);
    qx.push_back(a); qy.push_back(b); qs.push_back(s); qc.push_back(c);
  endtask

  task automatic gen_random(input int n);
    int ex, ap;
    for (int i = 0; i < n; i++) begin
      logic [15:0] a, b;
      logic [16:0] v;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ex = int'(a) + int'(b);
      case ($urandom_range(0, 2))
        0:       ap = ex;
        1:       ap = (ex ^ int'($urandom_range(1, 255))) & 32'h1FFFF;
        default: ap = int'($urandom_range(0, 32'h1FFFF));
      endcase
      v = 17'(ap);
      push(a, b, v[15:0], v[16]);
    end
  endtask

  task automatic do_start(input int num);
    start       = 1'b1;
    num_samples = 32'(num);
    @(negedge clk);
    start       = 1'b0;
  endtask

  // mode: 0 random valid, 1 always valid, 2 fixed 1,0,1,1,0,1 pattern.
  task automatic run_samples(input int n, input int mode, input int start_at);
    int          sent = 0;
    int          cyc  = 0;
    int          eerr = 0;
    longint      esum = 0;
    longint      esat;
    logic [16:0] emax = '0;
    int          ex, ap, ed;
    logic        v;
    logic [5:0]  pat = 6'b101101;
    while (sent < n && cyc < 200) begin
      v = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2) ? pat[5 - (cyc % 6)] : 1'b1;
      in_valid = v;
      x = qx[sent]; y = qy[sent]; s_apx = qs[sent]; co_apx = qc[sent];
      start = (cyc == start_at);
      total++;
      if (in_ready !== 1'b1 || in_ready_s !== 1'b1) begin
        bad++;
        $display("FAIL ready_run: got %b/%b want 1 (cycle %0d)", in_ready, in_ready_s, cyc);
      end
      if (v) begin
        ex = int'(qx[sent]) + int'(qy[sent]);
        ap = int'(qc[sent]) * 65536 + int'(qs[sent]);
        ed = (ex > ap) ? ex - ap : ap - ex;
        if (ed != 0) eerr++;
        esum += longint'(ed);
        if (ed > int'(emax)) emax = 17'(ed);
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL run_timeout: sent %0d want %0d", sent, n);
    end
    // Cycle after the last transfer: last sample not yet visible.
    total++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || sample_cnt !== 32'(n - 1)) begin
      bad++;
      $display("FAIL latency_c1: ready=%b res_valid=%b cnt=%0d want 0 0 %0d",
               in_ready, res_valid, sample_cnt, n - 1);
    end
    @(negedge clk);
    esat = (esum > 64'd262143) ? 64'd262143 : esum;
    total++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || sample_cnt !== 32'(n) || err_cnt !== 32'(eerr)) begin
      bad++;
      $display("FAIL done_counts: rv=%b busy=%b cnt=%0d err=%0d want 1 0 %0d %0d",
               res_valid, busy, sample_cnt, err_cnt, n, eerr);
    end
    total++;
    if (sum_ed !== esum[47:0] || max_ed !== emax) begin
      bad++;
      $display("FAIL done_ed: sum=%0d max=%h want %0d %h", sum_ed, max_ed, esum, emax);
    end
    total++;
    if (sum_ed_s !== esat[17:0] || res_valid_s !== 1'b1) begin
      bad++;
      $display("FAIL sat_sum: sum=%h rv=%b want %h 1", sum_ed_s, res_valid_s, esat[17:0]);
    end
    // Results must hold in DONE whatever appears on the inputs.
    in_valid = 1'b1;
    x = 16'($urandom); y = 16'($urandom); s_apx = 16'($urandom);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (res_valid !== 1'b1 || sample_cnt !== 32'(n) || sum_ed !== esum[47:0]) begin
      bad++;
      $display("FAIL done_hold: rv=%b cnt=%0d sum=%0d", res_valid, sample_cnt, sum_ed);
    end
    qx.delete(); qy.delete(); qs.delete(); qc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    x = '0; y = '0; s_apx = '0; co_apx = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || sample_cnt !== '0) begin
      bad++;
      $display("FAIL reset_init: ready=%b busy=%b rv=%b cnt=%0d", in_ready, busy, res_valid,
               sample_cnt);
    end
    do_start(5);
    in_valid = 1'b1; x = 16'h1234; y = 16'h4321; s_apx = 16'h0; co_apx = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || sample_cnt !== '0 ||
        err_cnt !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      bad++;
      $display("FAIL reset_midrun: ready=%b busy=%b rv=%b cnt=%0d err=%0d sum=%0d max=%0d",
               in_ready, busy, res_valid, sample_cnt, err_cnt, sum_ed, max_ed);
    end
    @(negedge clk);
    total++;
    if (sample_cnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_drain: cnt=%0d busy=%b want 0 0", sample_cnt, busy);
    end
  endtask

  task automatic test_single();
    push(16'h0001, 16'h0001, 16'h0002, 1'b0);
    do_start(1);
    run_samples(1, 1, -1);
  endtask

  task automatic test_two();
    push(16'h00FF, 16'h00FF, 16'h01F8, 1'b0);
    push(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    do_start(2);
    run_samples(2, 1, -1);
    total++;
    if (err_cnt !== 32'd2 || sum_ed !== 48'd65542 || max_ed !== 17'h10000) begin
      bad++;
      $display("FAIL two_const: err=%0d sum=%0d max=%h want 2 65542 10000", err_cnt, sum_ed,
               max_ed);
    end
  endtask

  task automatic test_zero();
    do_start(0);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_run: ready=%b busy=%b rv=%b want 0 1 0", in_ready, busy, res_valid);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || res_valid !== 1'b1 || sample_cnt !== '0 || err_cnt !== '0 ||
        sum_ed !== '0 || max_ed !== '0) begin
      bad++;
      $display("FAIL zero_done: ready=%b rv=%b cnt=%0d err=%0d sum=%0d max=%0d", in_ready,
               res_valid, sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_toggle();
    gen_random(4);
    do_start(4);
    run_samples(4, 2, -1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) push(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    do_start(8);
    run_samples(8, 1, 3);
    total++;
    if (sum_ed_s !== 18'h3FFFF || sum_ed !== 48'd524288) begin
      bad++;
      $display("FAIL sat_const: sat=%h full=%0d want 3ffff 524288", sum_ed_s, sum_ed);
    end
  endtask

  task automatic test_back_to_back();
    gen_random(3);
    do_start(3);
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b1 || sample_cnt !== '0 || sum_ed !== '0 ||
        max_ed !== '0) begin
      bad++;
      $display("FAIL b2b_clear: rv=%b busy=%b cnt=%0d sum=%0d max=%0d", res_valid, busy,
               sample_cnt, sum_ed, max_ed);
    end
    run_samples(3, 0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 15));
      gen_random(n);
      do_start(n);
      run_samples(n, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_zero();
    test_toggle();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
